// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU among NUM_REQ valid/ready requesters,
// with a registered single-entry response slot (result, zero, id, tag).
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;
endpackage

module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SH_W = $clog2(XLEN);
    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];
    always_comb begin
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_a,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_b,
    input  alu_op_e [NUM_REQ-1:0]              req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         resp_id,
    output logic [XLEN-1:0]                    resp_result,
    output logic                               resp_zero,
    output logic [TAG_W-1:0]                   resp_tag
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic            gnt_valid, accept;
    logic [ID_W-1:0] gnt_id, idx;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    alu_op_e         alu_op;
    logic            alu_zero;

    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Scan from the farthest offset down so the one nearest rr_ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        accept        = gnt_valid && (!resp_valid_q || resp_ready);
        req_ready     = accept ? NUM_REQ'(1) << gnt_id : '0;
        alu_a         = accept ? req_a[gnt_id] : '0;
        alu_b         = accept ? req_b[gnt_id] : '0;
        alu_op        = accept ? req_op[gnt_id] : ALU_ADD;
        resp_valid_d  = accept || (resp_valid_q && !resp_ready);
        resp_result_d = accept ? alu_result : resp_result_q;
        resp_zero_d   = accept ? alu_zero : resp_zero_q;
        resp_id_d     = accept ? gnt_id : resp_id_q;
        resp_tag_d    = accept ? req_tag[gnt_id] : resp_tag_q;
        rr_ptr_d      = !accept ? rr_ptr_q : (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_id_q     <= '0;
            resp_tag_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_id_q     <= resp_id_d;
            resp_tag_q    <= resp_tag_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_id     = resp_id_q;
    assign resp_tag    = resp_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of grants and the single response slot.
module tb_alu_arbiter;
    import riscv_pkg::*;
    localparam int N  = 2;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][31:0]    req_a, req_b;
    alu_op_e [N-1:0]       req_op;
    logic [N-1:0][TW-1:0]  req_tag;
    logic                  resp_valid, resp_ready, resp_zero;
    logic [0:0]            resp_id;
    logic [31:0]           resp_result;
    logic [TW-1:0]         resp_tag;

    int n_err = 0;
    int n_chk = 0;

    bit          m_valid;
    logic [31:0] m_result;
    bit          m_zero;
    int          m_id, m_ptr;
    logic [TW-1:0] m_tag;

    alu_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_result = '0; m_zero = 0; m_id = 0; m_tag = '0; m_ptr = 0;
    endtask

    task automatic set_req(input int i, input bit v, input alu_op_e op,
                           input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        req_valid[i] = v; req_op[i] = op; req_a[i] = a; req_b[i] = b; req_tag[i] = t;
    endtask

    // One clock: check req_ready mid-cycle, advance the model, check the slot after the edge.
    task automatic step(input string name);
        int g;
        bit free;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        free = !m_valid || resp_ready;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (free && g >= 0) exp_rdy[g] = 1'b1;
        chk({name, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (free && g >= 0) begin
            m_valid  = 1;
            m_result = ref_alu(req_op[g], req_a[g], req_b[g]);
            m_zero   = (m_result == 0);
            m_id     = g;
            m_tag    = req_tag[g];
            m_ptr    = (g + 1) % N;
        end else if (resp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk({name, ".valid"}, 32'(resp_valid), 32'(m_valid));
        chk({name, ".result"}, resp_result, m_result);
        chk({name, ".zero"}, 32'(resp_zero), 32'(m_zero));
        chk({name, ".id"}, 32'(resp_id), 32'(m_id));
        chk({name, ".tag"}, 32'(resp_tag), 32'(m_tag));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset.async_valid", 32'(resp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("reset.result", resp_result, 32'h0);
        chk("reset.zero", 32'(resp_zero), 32'h0);
        chk("reset.id", 32'(resp_id), 32'h0);
        chk("reset.tag", 32'(resp_tag), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_tag = '0; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) req_op[i] = ALU_ADD;
        #2;
        do_reset();
        step("idle");

        // 1: single op, unloaded
        set_req(0, 1, ALU_ADD, 32'd5, 32'd3, 4'd3);
        step("t1");
        chk("t1.sum", resp_result, 32'd8);
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        step("t1.drain");

        // 2: contention out of reset
        do_reset();
        set_req(0, 1, ALU_SUB, 32'd5, 32'd5, 4'd1);
        set_req(1, 1, ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 4'd2);
        step("t2.a");
        chk("t2.a_zero", 32'(resp_zero), 32'd1);
        chk("t2.a_id", 32'(resp_id), 32'd0);
        step("t2.b");
        chk("t2.b_result", resp_result, 32'hFFFF_FFFF);
        chk("t2.b_id", 32'(resp_id), 32'd1);

        // 3: round-robin, both held valid
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1, ALU_ADD, $urandom, $urandom, 4'(k));
            set_req(1, 1, ALU_OR, $urandom, $urandom, 4'(k + 8));
            step("t3");
            chk("t3.rot_id", 32'(resp_id), 32'(k % 2));
            chk("t3.rot_valid", 32'(resp_valid), 32'd1);
        end

        // 4: backpressure while SRA result is held
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        set_req(0, 1, ALU_SRA, 32'h8000_0000, 32'd1, 4'd7);
        step("t4.issue");
        chk("t4.sra", resp_result, 32'hC000_0000);
        resp_ready = 1'b0;
        set_req(0, 1, ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd9);
        for (int k = 0; k < 3; k++) begin
            step("t4.hold");
            chk("t4.hold_result", resp_result, 32'hC000_0000);
            chk("t4.hold_rdy", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        set_req(0, 1, ALU_ADD, 32'd1, 32'd1, 4'd4);
        step("t4.b2b");
        chk("t4.b2b_result", resp_result, 32'd2);
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        step("t4.drain");

        // 5: shift amount wraps at 32
        set_req(1, 1, ALU_SLL, 32'd1, 32'd37, 4'd5);
        step("t5");
        chk("t5.sll", resp_result, 32'h0000_0020);
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        step("t5.drain");

        // 6: reset with a held response; req0 grant leaves rr_ptr at 1 beforehand
        set_req(0, 1, ALU_OR, 32'h10, 32'h01, 4'd6);
        step("t6.issue");
        resp_ready = 1'b0;
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        step("t6.hold");
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 1, ALU_ADD, 32'd10, 32'd20, 4'd1);
        set_req(1, 1, ALU_ADD, 32'd30, 32'd40, 4'd2);
        step("t6.after");
        chk("t6.first_id", 32'(resp_id), 32'd0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), alu_op_e'($urandom_range(0, 9)),
                        ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom, 4'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
